// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: core-to-data-memory bus (store strobe, address, store data, load data)
interface dmem_mmio_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  modport master (output MemWrite, ALUResult, WriteData, input ReadData);
  modport slave (input MemWrite, ALUResult, WriteData, output ReadData);
endinterface

// File: rtl/dmem_mmio.sv
// dmem_mmio: word RAM plus MMIO page with LED register, 8N1 UART transmitter and cycle counter
module dmem_mmio #(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  dmem_mmio_if.slave  bus,
  output logic        uart_tx,
  output logic [7:0]  led
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int BW     = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [31:0]       ram [RAM_WORDS];
  logic [31:0]       cycle;
  state_t            state, state_n;
  logic [BW-1:0]     baud, baud_n;
  logic [2:0]        bit_idx, bit_n;
  logic [7:0]        data, data_n;
  logic              ram_sel, mmio_sel, busy, baud_done, unused_addr;
  logic [1:0]        off;
  logic [RAM_AW-1:0] idx;
  assign ram_sel     = bus.ALUResult[31:28] == 4'h0;
  assign mmio_sel    = bus.ALUResult[31:4] == 28'h1000000;
  assign off         = bus.ALUResult[3:2];
  assign idx         = bus.ALUResult[RAM_AW+1:2];
  assign unused_addr = ^bus.ALUResult[1:0];
  assign busy        = state != IDLE;
  assign baud_done   = baud == BW'(CLKS_PER_BIT - 1);
  // RAM store; contents survive reset, so no reset term here
  always_ff @(posedge clk)
    if (bus.MemWrite && ram_sel) ram[idx] <= bus.WriteData;
  // LED register and free-running cycle counter; a bus load overrides the increment
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      led   <= 8'h00;
      cycle <= 32'h0;
    end else begin
      if (bus.MemWrite && mmio_sel && off == 2'd0) led <= bus.WriteData[7:0];
      cycle <= (bus.MemWrite && mmio_sel && off == 2'd3) ? bus.WriteData : cycle + 32'd1;
    end
  // UART state register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= 3'd0;
      data    <= 8'h00;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      data    <= data_n;
    end
  // UART next-state: each of START/DATA bits/STOP lasts one full baud period
  always_comb begin
    state_n = state;
    baud_n  = baud_done ? '0 : baud + BW'(1);
    bit_n   = bit_idx;
    data_n  = data;
    case (state)
      IDLE: begin
        baud_n = '0;
        bit_n  = 3'd0;
        if (bus.MemWrite && mmio_sel && off == 2'd1) begin
          state_n = START;
          data_n  = bus.WriteData[7:0];
        end
      end
      START: state_n = baud_done ? DATA : START;
      DATA: if (baud_done) begin
        state_n = bit_idx == 3'd7 ? STOP : DATA;
        bit_n   = bit_idx + 3'd1;
      end
      STOP: state_n = baud_done ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // serial line is driven straight from state so reset forces idle-high at once
  always_comb
    uart_tx = state == START ? 1'b0 : state == DATA ? data[bit_idx] : 1'b1;
  // load data mux: RAM, then MMIO page, else zero
  always_comb
    bus.ReadData = ram_sel ? ram[idx] :
                   !mmio_sel ? 32'h0 :
                   off == 2'd0 ? {24'h0, led} :
                   off == 2'd2 ? {31'h0, busy} :
                   off == 2'd3 ? cycle : 32'h0;
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory subsystem directly downstream of the single-cycle CPU core. It consumes the core's MemWrite, ALUResult (address) and WriteData, and returns ReadData in the same cycle.
- Contains a word-addressed data RAM plus a memory-mapped peripheral page.
- Peripherals: LED register, 8N1 UART transmitter FSM, 32-bit loadable cycle counter.

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words; power of two; RAM_AW = log2(RAM_WORDS).
- CLKS_PER_BIT, 868, clock cycles per UART bit; minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemWrite  input  1  write strobe from core; one write per asserted cycle.
- ALUResult  input  32  byte address from core.
- WriteData  input  32  store data from core.
- ReadData  output  32  load data; combinational from ALUResult and current state.
- uart_tx  output  1  serial line; idles high.
- led  output  8  LED register contents.

Behaviour:
- Decode (Addr = ALUResult):
  - Addr[31:28]==0: RAM. Word index is Addr[RAM_AW+1:2]; higher bits ignored, so the region aliases.
  - Addr[31:4]==0x1000000: MMIO page. Offset is Addr[3:2].
  - Anything else is unmapped: read returns 0, write is ignored.
- Addr[1:0] is ignored everywhere. Only word access is supported; no byte enables.
- RAM:
  - Write is synchronous when MemWrite=1.
  - Read is asynchronous, so a read in the cycle after a write returns the new data.
  - Reset does not clear RAM contents.
- MMIO 0x1000_0000, LED:
  - Read returns {24'b0, led}.
  - Write loads WriteData[7:0] into led.
  - Reset value 0x00.
- MMIO 0x1000_0004, UART_TX:
  - Write while idle latches WriteData[7:0] and starts a frame.
  - Write while busy is silently dropped.
  - Read returns 0.
- MMIO 0x1000_0008, UART_STATUS: read returns {31'b0, busy}; write is ignored.
- MMIO 0x1000_000C, CYCLE:
  - Read returns the current counter value.
  - Counter increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - Write loads WriteData; the load wins over the increment. The value reads WriteData in the next cycle and WriteData+1 in the one after.
  - Reset value 0.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. An accepted write moves to START on the next edge; busy=1 from that edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: sends bits 0..7, LSB first, each held CLKS_PER_BIT cycles. A 3-bit bit index and a baud counter control progression.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE with busy=0.
  - Total frame length is 10*CLKS_PER_BIT cycles. A new write is accepted in the first IDLE cycle after STOP.
- Reset, including mid-frame:
  - FSM goes to IDLE; uart_tx=1, busy=0; baud counter and bit index cleared.
  - led=0, cycle counter=0.
  - ReadData follows decode immediately.
- Simultaneous events: only one bus access per cycle exists. The counter increment and UART progression run independently of bus traffic.
- Width rules: all counters are unsigned. The baud counter width is clog2(CLKS_PER_BIT).

Test Plan:
- RAM: write 0xDEADBEEF at 0x0000_0010, next cycle read 0x0000_0010 -> 0xDEADBEEF. With RAM_WORDS=1024, read 0x0000_1010 -> 0xDEADBEEF (alias). Read 0x2000_0000 -> 0.
- LED: write 0x1234_56A5 to 0x1000_0000 -> led=0xA5 and read returns 0x0000_00A5. Then assert reset -> led=0x00.
- UART frame, CLKS_PER_BIT=4: write 0xA5 to 0x1000_0004.
  - uart_tx shows 4 cycles of 0, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles of 1.
  - STATUS reads 1 for exactly 40 cycles, then 0.
- UART busy drop: write 0x3C during the 0xA5 frame -> frame unchanged, no second frame follows. A write of 0x3C after busy=0 -> a 0x3C frame is sent.
- Counter: write 0xFFFF_FFFE to 0x1000_000C -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on three consecutive cycles.
- Reset mid-frame: assert reset during DATA bit 3 -> uart_tx=1 and busy=0 immediately. After release, a write of 0x55 produces a clean full frame.
